// File: rtl/sync_fifo_pkg.sv
// Shared constants, address-width helper, count type and flag decoding
// for the parametrised synchronous FIFO.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 8;

    // Pointer width for a given depth; a depth below 2 still needs one bit.
    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    typedef logic [addr_w(DEF_FIFO_DEPTH):0] def_count_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // All status flags derive from the occupancy count alone.
    function automatic fifo_flags_t decode_flags(
        input int cnt,
        input int depth,
        input int af_level,
        input int ae_level
    );
        fifo_flags_t f;
        f.full         = (cnt == depth);
        f.empty        = (cnt == 0);
        f.almost_full  = (cnt >= af_level);
        f.almost_empty = (cnt <= ae_level);
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage for sync_fifo_param: one synchronous write port,
// one asynchronous read port. Contents are never reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int ADDR_W    = addr_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_reg [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] row_we;

    // One-hot write decode keeps each row an independent enable flop bank.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_row_we
            assign row_we[gi] = wr_en && (wr_addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (row_we[i]) begin
                mem_reg[i] <= wr_data;
            end
        end
    end

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and
// overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    localparam int ADDR_W    = addr_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  Full,
    output logic                  Empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_W:0]       count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;
    fifo_flags_t           flags;

    assign flags = decode_flags(int'(count_reg), FIFO_DEPTH, AF_LEVEL, AE_LEVEL);

    // A read is judged first so a write on full can ride on a concurrent pop;
    // a read on empty is never rescued by a concurrent write.
    assign rd_acc = cs && rd_en && !flags.empty;
    assign wr_acc = cs && wr_en && (!flags.full || rd_acc);

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_reg),
        .wr_data (data_in),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = cs && wr_en && !wr_acc;
        underflow_next = cs && rd_en && !rd_acc;
        if (wr_acc) begin
            wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_next = count_reg + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; a pop simply advances rd_ptr.
    assign data_out = rd_data;
`else
    logic [DATA_WIDTH-1:0] data_out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_reg <= '0;
        end else if (rd_acc) begin
            data_out_reg <= rd_data;
        end
    end

    assign data_out = data_out_reg;
`endif

    assign count        = count_reg;
    assign Full         = flags.full;
    assign Empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed plus randomized bench for sync_fifo_param, checked every cycle
// against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          Full, Empty, almost_full, almost_empty;
    logic [3:0]    count;
    logic          overflow, underflow;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_dout = '0;
    logic          exp_ov = 1'b0;
    logic          exp_un = 1'b0;

    sync_fifo_param #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cs           (cs),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .Full         (Full),
        .Empty        (Empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic check_all();
        int n;
        n = model_q.size();
        check("count", DW'(count), DW'(n));
        check("Full", DW'(Full), DW'(n == DEPTH));
        check("Empty", DW'(Empty), DW'(n == 0));
        check("almost_full", DW'(almost_full), DW'(n >= AF));
        check("almost_empty", DW'(almost_empty), DW'(n <= AE));
        check("overflow", DW'(overflow), DW'(exp_ov));
        check("underflow", DW'(underflow), DW'(exp_un));
`ifdef SYNC_FIFO_FWFT_EN
        if (n != 0) check("data_out", data_out, model_q[0]);
`else
        check("data_out", data_out, exp_dout);
`endif
    endtask

    // One clock: apply inputs, advance the model by the accept rules, compare.
    task automatic cycle(input logic c, input logic w, input logic r,
                         input logic [DW-1:0] d, input logic do_rst);
        logic ra, wa;
        cs = c; wr_en = w; rd_en = r; data_in = d; rst = do_rst;
        ra = c && r && (model_q.size() > 0);
        wa = c && w && ((model_q.size() < DEPTH) || ra);
        @(posedge clk);
        #1;
        if (do_rst) begin
            model_q.delete();
            exp_dout = '0;
            exp_ov   = 1'b0;
            exp_un   = 1'b0;
        end else begin
            if (ra) exp_dout = model_q.pop_front();
            if (wa) model_q.push_back(d);
            exp_ov = c && w && !wa;
            exp_un = c && r && !ra;
        end
        check_all();
    endtask

    task automatic wr(input logic [DW-1:0] d);
        cycle(1'b1, 1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic rd();
        cycle(1'b1, 1'b0, 1'b1, '0, 1'b0);
    endtask

    initial begin
        // Reset
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Simple write three, read three
        wr(32'd1); wr(32'd100); wr(32'd1000);
        check("cnt_after_3w", DW'(count), 32'd3);
        rd(); rd(); rd();
        check("empty_after_3r", DW'(Empty), 32'd1);

        // Fill with powers of two, overflow, write+read on full, drain
        for (int i = 0; i < DEPTH; i++) wr(DW'(1) << i);
        check("full_after_fill", DW'(Full), 32'd1);
        wr(32'hDEAD);
        check("ovf_pulse", DW'(overflow), 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 32'h55, 1'b0);
        check("full_rw_keep", DW'(Full), 32'd1);
        for (int i = 0; i < DEPTH; i++) rd();
        check("last_is_55", data_out, 32'h55);

        // Underflow on empty, then read+write on empty
        rd();
        check("unf_pulse", DW'(underflow), 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 32'hABC, 1'b0);
        check("cnt_rw_empty", DW'(count), 32'd1);

        // cs low: requests ignored, no pulses
        cycle(1'b0, 1'b1, 1'b1, 32'h77, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        rd();

        // Two fill/drain passes across pointer wrap
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) wr($urandom);
            for (int i = 0; i < DEPTH; i++) rd();
        end

        // Randomized traffic with write-heavy and read-heavy phases
        for (int i = 0; i < 600; i++) begin
            logic c, w, r, rs;
            int bias;
            bias = ((i / 60) % 2 == 0) ? 75 : 25;
            c  = ($urandom_range(0, 9) != 0);
            w  = ($urandom_range(0, 99) < bias);
            r  = ($urandom_range(0, 99) < (100 - bias));
            rs = ($urandom_range(0, 99) == 0);
            cycle(c, w, r, $urandom, rs);
        end

        // Reset mid-stream with count=5 and a pending write
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) wr(DW'(i + 10));
        check("cnt5", DW'(count), 32'd5);
        cycle(1'b1, 1'b1, 1'b0, 32'h99, 1'b1);
        check("rst_cnt0", DW'(count), 32'd0);
        check("rst_no_ovf", DW'(overflow), 32'd0);

        // Single write then idle: FWFT presents it without a read
        wr(32'd7);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        rd();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
